mem_port_arbiter: RTL and testbench

- Shares the single external data-memory port between two requesters: the instruction-fetch path and the load/store path.
- Sits between IF_Stage / Ext_Memory access logic and the memory, so fetch and data accesses can coexist on a memory with variable latency.
- Priority is fixed data-first, with an anti-starvation streak limit for fetch.
- Accepts one transaction at a time, sequences the memory handshake, applies a completion timeout and returns a response pulse to the owning requester.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_arb_prio.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// The memory type codes reuse the Control_Unit func3 encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic [2:0] MT_LB  = 3'b000;
  localparam logic [2:0] MT_LH  = 3'b001;
  localparam logic [2:0] MT_LW  = 3'b010;
  localparam logic [2:0] MT_LBU = 3'b100;
  localparam logic [2:0] MT_LHU = 3'b101;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Requests are level-held with stable fields until the matching gnt (a
  // combinational, same-cycle accept); each accepted request gets exactly one
  // rvalid pulse later. mem_req stays high with stable fields until mem_ready.
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;

  logic          d_req;
  logic          d_we;
  logic [2:0]    d_type;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;

  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  logic          mem_req;
  logic          mem_we;
  logic [2:0]    mem_type;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_type, d_addr, d_wdata,
    input  mem_ready, mem_rdata,
    output if_gnt, if_rvalid, d_gnt, d_rvalid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_type, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_type, d_addr, d_wdata,
    output mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, d_gnt, d_rvalid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_type, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Data-first winner select with a streak limit that lets a waiting fetch
// through after MAX_D_STREAK consecutive data grants.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter  int MAX_D_STREAK = 3,
  localparam int SW           = $clog2(MAX_D_STREAK + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_arb_en,
  input  logic          i_if_req,
  input  logic          i_d_req,
  output logic          o_if_gnt,
  output logic          o_d_gnt,
  output owner_t        o_winner,
  output logic [SW-1:0] o_streak
);

  logic [SW-1:0] r_streak;
  logic          w_sat;
  logic          w_if_gnt;
  logic          w_d_gnt;

  assign w_sat    = (r_streak == SW'(MAX_D_STREAK));
  assign w_if_gnt = i_arb_en & i_if_req & (~i_d_req | w_sat);
  assign w_d_gnt  = i_arb_en & i_d_req & ~(i_if_req & w_sat);

  // Only data grants that made a fetch wait count toward the streak.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_streak <= '0;
    end else if (w_if_gnt) begin
      r_streak <= '0;
    end else if (w_d_gnt) begin
      if (!i_if_req) begin
        r_streak <= '0;
      end else if (!w_sat) begin
        r_streak <= r_streak + SW'(1);
      end
    end
  end

  assign o_if_gnt = w_if_gnt;
  assign o_d_gnt  = w_d_gnt;
  assign o_winner = w_if_gnt ? OWN_IF : OWN_D;
  assign o_streak = r_streak;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store: one transaction at a
// time, registered memory handshake, completion timeout, per-owner response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int AW           = 32,
  parameter  int DW           = 32,
  parameter  int MAX_D_STREAK = 3,
  parameter  int TIMEOUT      = 64,
  localparam int SW           = $clog2(MAX_D_STREAK + 1),
  localparam int TW           = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output arb_state_t          o_dbg_state,
  output logic [SW-1:0]       o_dbg_streak
);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic          w_done;
  logic          w_tmo;
  logic          w_tmo_hit;
  logic          w_arb_en;
  logic          w_if_gnt;
  logic          w_d_gnt;
  owner_t        w_winner;

  logic          r_mem_req;
  logic          r_mem_we;
  logic [2:0]    r_mem_type;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_if_rvalid;
  logic          r_d_rvalid;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_err;
  logic [TW-1:0] r_tmo_cnt;

  // Grants are suppressed while reset is held so nothing is captured then.
  assign w_arb_en = (r_state == IDLE) && reset;

  mem_arb_prio #(.MAX_D_STREAK(MAX_D_STREAK)) u_prio (
    .clk      (clk),
    .reset    (reset),
    .i_arb_en (w_arb_en),
    .i_if_req (bus.if_req),
    .i_d_req  (bus.d_req),
    .o_if_gnt (w_if_gnt),
    .o_d_gnt  (w_d_gnt),
    .o_winner (w_winner),
    .o_streak (o_dbg_streak)
  );

  assign w_tmo_hit = (TIMEOUT != 0) && (r_tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A late mem_ready in the timeout cycle still counts as a normal completion.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_if_gnt) begin
          w_state_nxt = BUSY_I;
        end else if (w_d_gnt) begin
          w_state_nxt = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_type  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_rsp_err   <= 1'b0;
      if (r_state == IDLE) begin
        if (w_if_gnt || w_d_gnt) begin
          r_mem_req <= 1'b1;
          r_tmo_cnt <= '0;
          if (w_winner == OWN_IF) begin
            r_mem_we    <= 1'b0;
            r_mem_type  <= MT_LW;
            r_mem_addr  <= bus.if_addr;
            r_mem_wdata <= '0;
          end else begin
            r_mem_we    <= bus.d_we;
            r_mem_type  <= bus.d_type;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
          end
        end
      end else if (w_done || w_tmo) begin
        r_mem_req   <= 1'b0;
        r_if_rvalid <= (r_state == BUSY_I);
        r_d_rvalid  <= (r_state == BUSY_D);
        r_rsp_err   <= w_tmo;
        if (w_tmo) begin
          r_rsp_rdata <= '0;
        end else if (!r_mem_we) begin
          r_rsp_rdata <= bus.mem_rdata;
        end
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_type  = r_mem_type;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for single
// transactions plus hand sequences for contention, timeout, reset and streaming.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic       clk;
  logic       reset;
  arb_state_t dbg_state;
  logic [1:0] dbg_streak;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(
    .AW(32), .DW(32), .MAX_D_STREAK(3), .TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .o_dbg_state  (dbg_state),
    .o_dbg_streak (dbg_streak)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_type;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_if_rvalid;
    logic        e_d_rvalid;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [2:0]  e_mem_type;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic [31:0] e_rsp_rdata;
    logic        e_rsp_err;
  } vec_t;

  vec_t vecs[14];

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_type    = '0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic drive_d(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_type  = typ;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
  endtask

  task automatic apply_vec(input vec_t v);
    bus.if_req    = v.if_req;
    bus.if_addr   = v.if_addr;
    bus.d_req     = v.d_req;
    bus.d_we      = v.d_we;
    bus.d_type    = v.d_type;
    bus.d_addr    = v.d_addr;
    bus.d_wdata   = v.d_wdata;
    bus.mem_ready = v.mem_ready;
    bus.mem_rdata = v.mem_rdata;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d.if_gnt", i),    32'(bus.if_gnt),    32'(v.e_if_gnt));
    chk($sformatf("v%0d.d_gnt", i),     32'(bus.d_gnt),     32'(v.e_d_gnt));
    chk($sformatf("v%0d.if_rvalid", i), 32'(bus.if_rvalid), 32'(v.e_if_rvalid));
    chk($sformatf("v%0d.d_rvalid", i),  32'(bus.d_rvalid),  32'(v.e_d_rvalid));
    chk($sformatf("v%0d.mem_req", i),   32'(bus.mem_req),   32'(v.e_mem_req));
    chk($sformatf("v%0d.mem_we", i),    32'(bus.mem_we),    32'(v.e_mem_we));
    chk($sformatf("v%0d.mem_type", i),  32'(bus.mem_type),  32'(v.e_mem_type));
    chk($sformatf("v%0d.mem_addr", i),  bus.mem_addr,       v.e_mem_addr);
    chk($sformatf("v%0d.mem_wdata", i), bus.mem_wdata,      v.e_mem_wdata);
    chk($sformatf("v%0d.rsp_rdata", i), bus.rsp_rdata,      v.e_rsp_rdata);
    chk($sformatf("v%0d.rsp_err", i),   32'(bus.rsp_err),   32'(v.e_rsp_err));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_busy;
    bit seen;

    //            if  if_addr       d  we typ     d_addr        d_wdata       rdy rdata      | ig dg irv drv mrq mwe mtype   maddr         mwdata        rdata         err
    // fetch alone, zero-wait memory
    vecs[0]  = '{1, 32'h100,  0, 0, 3'd0,   32'h0,    32'h0,        0, 32'h0,        1, 0, 0, 0, 0, 0, 3'd0,   32'h0,    32'h0,        32'h0,        0};
    vecs[1]  = '{0, 32'h0,    0, 0, 3'd0,   32'h0,    32'h0,        1, 32'h00500093, 0, 0, 0, 0, 1, 0, MT_LW,  32'h100,  32'h0,        32'h0,        0};
    vecs[2]  = '{0, 32'h0,    0, 0, 3'd0,   32'h0,    32'h0,        0, 32'h0,        0, 0, 1, 0, 0, 0, MT_LW,  32'h100,  32'h0,        32'h00500093, 0};
    vecs[3]  = '{0, 32'h0,    0, 0, 3'd0,   32'h0,    32'h0,        0, 32'h0,        0, 0, 0, 0, 0, 0, MT_LW,  32'h100,  32'h0,        32'h00500093, 0};
    // store, ready in the third busy cycle; read data must be ignored
    vecs[4]  = '{0, 32'h0,    1, 1, MT_LW,  32'h2000, 32'hDEADBEEF, 0, 32'h0,        0, 1, 0, 0, 0, 0, MT_LW,  32'h100,  32'h0,        32'h00500093, 0};
    vecs[5]  = '{0, 32'h0,    0, 0, 3'd0,   32'h0,    32'h0,        0, 32'h0,        0, 0, 0, 0, 1, 1, MT_LW,  32'h2000, 32'hDEADBEEF, 32'h00500093, 0};
    vecs[6]  = '{0, 32'h0,    0, 0, 3'd0,   32'h0,    32'h0,        0, 32'h0,        0, 0, 0, 0, 1, 1, MT_LW,  32'h2000, 32'hDEADBEEF, 32'h00500093, 0};
    vecs[7]  = '{0, 32'h0,    0, 0, 3'd0,   32'h0,    32'h0,        1, 32'h12345678, 0, 0, 0, 0, 1, 1, MT_LW,  32'h2000, 32'hDEADBEEF, 32'h00500093, 0};
    vecs[8]  = '{0, 32'h0,    0, 0, 3'd0,   32'h0,    32'h0,        0, 32'h0,        0, 0, 0, 1, 0, 1, MT_LW,  32'h2000, 32'hDEADBEEF, 32'h00500093, 0};
    // mem_ready while idle is ignored
    vecs[9]  = '{0, 32'h0,    0, 0, 3'd0,   32'h0,    32'h0,        1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1, MT_LW,  32'h2000, 32'hDEADBEEF, 32'h00500093, 0};
    vecs[10] = '{0, 32'h0,    0, 0, 3'd0,   32'h0,    32'h0,        0, 32'h0,        0, 0, 0, 0, 0, 1, MT_LW,  32'h2000, 32'hDEADBEEF, 32'h00500093, 0};
    // byte load unsigned
    vecs[11] = '{0, 32'h0,    1, 0, MT_LBU, 32'h3001, 32'h0,        0, 32'h0,        0, 1, 0, 0, 0, 1, MT_LW,  32'h2000, 32'hDEADBEEF, 32'h00500093, 0};
    vecs[12] = '{0, 32'h0,    0, 0, 3'd0,   32'h0,    32'h0,        1, 32'h000000A5, 0, 0, 0, 0, 1, 0, MT_LBU, 32'h3001, 32'h0,        32'h00500093, 0};
    vecs[13] = '{0, 32'h0,    0, 0, 3'd0,   32'h0,    32'h0,        0, 32'h0,        0, 0, 0, 1, 0, 0, MT_LBU, 32'h3001, 32'h0,        32'h000000A5, 0};

    // ---- reset: requests high while held in reset must not be granted ----
    idle_inputs();
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    reset = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst.if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("rst.d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("rst.mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst.mem_addr", bus.mem_addr, 32'd0);
    chk("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst.rvalid", 32'({bus.if_rvalid, bus.d_rvalid, bus.rsp_err}), 32'd0);
    chk("rst.state", 32'(dbg_state), 32'(IDLE));
    chk("rst.streak", 32'(dbg_streak), 32'd0);
    next_cycle();
    idle_inputs();
    reset = 1'b1;

    // ---- table vectors ----
    for (int i = 0; i < 14; i++) begin
      apply_vec(vecs[i]);
      @(negedge clk);
      check_vec(i, vecs[i]);
      next_cycle();
    end

    // ---- contention: grant order D,D,D,I,D,D,D,I with zero-wait memory ----
    idle_inputs();
    exp_q = {"D", "D", "D", "I", "D", "D", "D", "I"};
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h400;
    drive_d(1'b0, MT_LW, 32'h800, 32'h0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h11;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("cont.one_gnt", 32'(bus.if_gnt & bus.d_gnt), 32'd0);
      if (bus.if_gnt || bus.d_gnt) begin
        if (exp_q.size() == 0) chk("cont.extra_gnt", 32'd1, 32'd0);
        else chk($sformatf("cont.order%0d", i), 32'(bus.if_gnt ? 8'h49 : 8'h44), 32'(exp_q.pop_front()));
      end
      next_cycle();
    end
    chk("cont.missing_gnts", 32'(exp_q.size()), 32'd0);
    idle_inputs();
    next_cycle();

    // ---- timeout: load never completes ----
    drive_d(1'b0, MT_LW, 32'h500, 32'h0);
    @(negedge clk);
    chk("tmo.gnt", 32'(bus.d_gnt), 32'd1);
    next_cycle();
    bus.d_req = 1'b0;
    n_busy = 0;
    seen   = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_req) n_busy++;
      if (bus.d_rvalid) begin
        seen = 1'b1;
        chk("tmo.err", 32'(bus.rsp_err), 32'd1);
        chk("tmo.rdata", bus.rsp_rdata, 32'd0);
        chk("tmo.mem_req", 32'(bus.mem_req), 32'd0);
        chk("tmo.state", 32'(dbg_state), 32'(IDLE));
      end
      next_cycle();
    end
    chk("tmo.seen", 32'(seen), 32'd1);
    chk("tmo.busy_cycles", 32'(n_busy), 32'd4);

    // ---- mem_ready in the timeout cycle wins ----
    drive_d(1'b0, MT_LH, 32'h510, 32'h0);
    next_cycle();
    bus.d_req = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h77;
    @(negedge clk);
    chk("race.mem_req", 32'(bus.mem_req), 32'd1);
    next_cycle();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("race.rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("race.err", 32'(bus.rsp_err), 32'd0);
    chk("race.rdata", bus.rsp_rdata, 32'h77);
    next_cycle();

    // ---- reset in the middle of a data access ----
    bus.if_req = 1'b1;
    bus.if_addr = 32'h600;
    drive_d(1'b0, MT_LW, 32'h700, 32'h0);
    @(negedge clk);
    chk("rmid.d_gnt", 32'(bus.d_gnt), 32'd1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("rmid.busy", 32'(bus.mem_req), 32'd1);
    chk("rmid.streak1", 32'(dbg_streak), 32'd1);
    next_cycle();
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h99;
    next_cycle();
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("rmid.mem_req", 32'(bus.mem_req), 32'd0);
    chk("rmid.rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("rmid.streak", 32'(dbg_streak), 32'd0);
    chk("rmid.state", 32'(dbg_state), 32'(IDLE));
    chk("rmid.rdata", bus.rsp_rdata, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rmid.rvalid2", 32'(bus.d_rvalid), 32'd0);
    next_cycle();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h600;
    @(negedge clk);
    chk("rmid.if_gnt", 32'(bus.if_gnt), 32'd1);
    next_cycle();
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFE;
    @(negedge clk);
    chk("rmid.if_addr", bus.mem_addr, 32'h600);
    next_cycle();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("rmid.if_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("rmid.if_rdata", bus.rsp_rdata, 32'hCAFE);
    next_cycle();

    // ---- back-to-back fetches: gnt every other cycle, alongside rvalid ----
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h900;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.mem_rdata = 32'(i + 1);
      @(negedge clk);
      chk($sformatf("b2b.gnt%0d", i), 32'(bus.if_gnt), 32'(i % 2 == 0));
      chk($sformatf("b2b.rvalid%0d", i), 32'(bus.if_rvalid), 32'((i % 2 == 0) && (i > 0)));
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
